// File: rtl/instr_line_fetch.sv
// Instruction line fetch: AXI4 INCR burst read master that assembles
// BEATS read beats into one instruction-cache line.
module instr_line_fetch #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_start_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [7:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  output logic [LINE_WIDTH-1:0] o_line,
  output logic                  o_read_last,
  output logic                  o_error,
  output logic                  o_busy
);

  localparam int BEATS = LINE_WIDTH / DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int SIZE  = $clog2(DATA_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             err;
  logic             err_n;
  logic             load;
  logic             take;
  logic             is_last;
  logic             beat_bad;

  assign o_arlen   = 8'(BEATS - 1);
  assign o_arsize  = 3'(SIZE);
  assign o_arburst = 2'b01;

  // o_rready is high exactly while in DATA
  assign take     = o_rready & i_rvalid;
  assign is_last  = (cnt == LAST);
  assign beat_bad = i_rresp[1] | (i_rlast != is_last);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start_read) begin
          state_n = ADDR;
          cnt_n   = '0;
          err_n   = 1'b0;
          load    = 1'b1;
        end
      end
      ADDR: begin
        if (i_arready) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (take) begin
          cnt_n = cnt + 1'b1;
          err_n = err | beat_bad;
          // beat count, not rlast, ends the burst
          if (is_last) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      cnt         <= '0;
      err         <= 1'b0;
      o_araddr    <= '0;
      o_line      <= '0;
      o_arvalid   <= 1'b0;
      o_rready    <= 1'b0;
      o_read_last <= 1'b0;
      o_error     <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      err         <= err_n;
      o_arvalid   <= (state_n == ADDR);
      o_rready    <= (state_n == DATA);
      o_read_last <= (state_n == DONE);
      o_error     <= (state_n == DONE) & err_n;
      o_busy      <= (state_n != IDLE);
      if (load) begin
        o_araddr <= {i_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      end
      if (take) begin
        o_line[cnt*DATA_WIDTH +: DATA_WIDTH] <= i_rdata;
      end
    end
  end

endmodule

// File: tb/tb_instr_line_fetch.sv
// Scoreboard bench for instr_line_fetch: directed fetches push expected
// lines; a forked monitor pops and compares on each o_read_last.
`timescale 1ns/1ps
module tb_instr_line_fetch;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int LW    = 512;
  localparam int BEATS = 8;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          i_start_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [AW-1:0] o_araddr;
  logic [7:0]    o_arlen;
  logic [2:0]    o_arsize;
  logic [1:0]    o_arburst;
  logic          o_arvalid;
  logic          i_arready = 1'b0;
  logic [DW-1:0] i_rdata = '0;
  logic [1:0]    i_rresp = '0;
  logic          i_rlast = 1'b0;
  logic          i_rvalid = 1'b0;
  logic          o_rready;
  logic [LW-1:0] o_line;
  logic          o_read_last;
  logic          o_error;
  logic          o_busy;

  instr_line_fetch #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LINE_WIDTH(LW)
  ) dut (
    .clk(clk),
    .arst(arst),
    .i_start_read(i_start_read),
    .i_addr(i_addr),
    .o_araddr(o_araddr),
    .o_arlen(o_arlen),
    .o_arsize(o_arsize),
    .o_arburst(o_arburst),
    .o_arvalid(o_arvalid),
    .i_arready(i_arready),
    .i_rdata(i_rdata),
    .i_rresp(i_rresp),
    .i_rlast(i_rlast),
    .i_rvalid(i_rvalid),
    .o_rready(o_rready),
    .o_line(o_line),
    .o_read_last(o_read_last),
    .o_error(o_error),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [LW-1:0] line;
    logic          err;
    logic [AW-1:0] addr;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] exp_araddr = '0;
  int            checks = 0;
  int            failures = 0;

  function automatic void chk(string name, logic [63:0] got,
                              logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic void chk_line(string name, logic [LW-1:0] got,
                                   logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic logic [DW-1:0] beat_data(int k, logic [DW-1:0] salt);
    return (64'(k) * 64'h1111_1111_1111_1111) ^ salt;
  endfunction

  task automatic monitor();
    exp_t e;
    int   beats = 0;
    int   ars = 0;
    int   start_cyc = 0;
    bit   saw_done = 0;
    bit   saw_start = 0;
    forever begin
      @(negedge clk);
      if (arst) begin
        beats = 0;
        ars = 0;
        saw_done = 0;
        saw_start = 0;
        chk("rst_araddr", o_araddr, 64'h0);
        chk_line("rst_line", o_line, '0);
        chk("rst_flags", 64'({o_arvalid, o_rready, o_read_last,
                              o_error, o_busy}), 64'h0);
        chk("rst_arlen", 64'(o_arlen), 64'd7);
      end else begin
        if (saw_done) begin
          chk("idle_gap_busy", 64'(o_busy), 64'd0);
          chk("last_one_cycle", 64'(o_read_last), 64'd0);
        end
        if (saw_start) begin
          chk("busy_after_start", 64'(o_busy), 64'd1);
          chk("arvalid_after_start", 64'(o_arvalid), 64'd1);
        end
        saw_done = 0;
        saw_start = 0;
        if (o_arvalid) chk("araddr_stable", o_araddr, exp_araddr);
        if (o_arvalid && i_arready) ars++;
        if (o_rready && i_rvalid) beats++;
        if (o_error) chk("error_with_last", 64'(o_read_last), 64'd1);
        if (i_start_read && !o_busy) begin
          start_cyc = cyc;
          saw_start = 1;
        end
        if (o_read_last) begin
          saw_done = 1;
          chk("sb_pending", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_line("line", o_line, e.line);
            chk("error", 64'(o_error), 64'(e.err));
            chk("araddr", o_araddr, e.addr);
            if (e.lat >= 0) chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
          end
          chk("beats", 64'(beats), 64'd8);
          chk("ar_count", 64'(ars), 64'd1);
          chk("busy_at_done", 64'(o_busy), 64'd1);
          chk("ar_consts", 64'({o_arlen, o_arsize, o_arburst}),
              64'({8'd7, 3'd3, 2'd1}));
          beats = 0;
          ars = 0;
        end
      end
    end
  endtask

  task automatic run_fetch(input logic [AW-1:0] addr,
                           input logic [DW-1:0] salt,
                           input int ar_stall, input bit gaps,
                           input int err_beat, input int last_beat,
                           input int poke_beat, input int abort_after,
                           input logic [AW-1:0] x_addr, input bit x_err,
                           input int lat);
    exp_t e;
    int   n;
    e.line = '0;
    for (int k = 0; k < BEATS; k++) e.line[k*DW +: DW] = beat_data(k, salt);
    e.err  = x_err;
    e.addr = x_addr;
    e.lat  = lat;
    @(posedge clk); #1;
    exp_araddr = x_addr;
    if (abort_after < 0) sb.push_back(e);
    i_addr = addr;
    i_start_read = 1'b1;
    i_arready = (ar_stall == 0);
    @(posedge clk); #1;
    i_start_read = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(o_arvalid && i_arready) && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (n >= ar_stall) i_arready = 1'b1;
      @(negedge clk);
    end
    if (!(o_arvalid && i_arready)) chk("ar_wait", 64'(o_arvalid), 64'd1);
    @(posedge clk); #1;
    i_arready = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      if (gaps && k > 0) begin
        i_rvalid = 1'b0;
        @(posedge clk); #1;
      end
      i_rvalid = 1'b1;
      i_rdata  = beat_data(k, salt);
      i_rlast  = (k == last_beat);
      i_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      if (k == poke_beat) begin
        i_start_read = 1'b1;
        i_addr = ~addr;
      end
      @(negedge clk);
      n = 0;
      while (!o_rready && n < 64) begin
        n++;
        @(negedge clk);
      end
      if (!o_rready) chk("rready_wait", 64'(o_rready), 64'd1);
      @(posedge clk); #1;
      i_start_read = 1'b0;
      i_addr = addr;
      if (k == abort_after) begin
        i_rvalid = 1'b0;
        i_rlast = 1'b0;
        i_rresp = 2'b00;
        arst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        arst = 1'b0;
        return;
      end
    end
    i_rvalid = 1'b0;
    i_rlast = 1'b0;
    i_rresp = 2'b00;
    @(negedge clk);
    n = 0;
    while (!o_read_last && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (!o_read_last) chk("done_wait", 64'(o_read_last), 64'd1);
  endtask

  initial begin
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    // basic fetch: line-aligned 0x1000, done at cycle 10
    run_fetch(64'h1038, 64'h0, 0, 0, -1, 7, -1, -1, 64'h1000, 0, 10);
    chk("basic_beat0", o_line[63:0], 64'h0);
    chk("basic_beat7", o_line[511:448], 64'h7777_7777_7777_7777);
    // 3 AR stall cycles + 7 R gaps
    run_fetch(64'h1038, 64'h0, 3, 1, -1, 7, -1, -1, 64'h1000, 0, 20);
    run_fetch(64'h2040, 64'hA5A5_0000_0000_5A5A, 0, 0, 3, 7, -1, -1,
              64'h2040, 1, 10);
    run_fetch(64'h3007F, 64'h0123_4567_89AB_CDEF, 0, 0, -1, 5, -1, -1,
              64'h30040, 1, 10);
    run_fetch(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_0000_FFFF_0000, 0, 0,
              -1, -1, -1, -1, 64'hFFFF_FFFF_FFFF_FFC0, 1, 10);
    // request during DATA is dropped; next one follows back to back
    run_fetch(64'h4000, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, -1, 7, 3, -1,
              64'h4000, 0, 10);
    run_fetch(64'h5008, 64'h3C3C_3C3C_0000_0000, 0, 0, -1, 7, -1, -1,
              64'h5000, 0, 10);
    run_fetch(64'h6000, 64'hDEAD_BEEF_0000_0000, 0, 0, -1, 7, -1, 4,
              64'h6000, 0, -1);
    run_fetch(64'h7010, 64'h0000_0000_CAFE_F00D, 0, 0, -1, 7, -1, -1,
              64'h7000, 0, 10);
    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/instr_line_fetch.md
# instr_line_fetch

AXI4 read master that fetches one instruction-cache line as a single INCR burst and assembles the beats into a 512-bit line for the instruction cache. It sits directly upstream of the instruction cache. On a miss, the control unit pulses `i_start_read`. This block issues the burst, collects the beats, then presents the full line on `o_line` together with a one-cycle `o_read_last`; that pulse is the cache write strobe.

## Interface
- `ADDR_WIDTH`, 64, byte-address width of `i_addr` and `o_araddr`.
- `DATA_WIDTH`, 64, AXI read data width in bits; legal values are 32, 64, 128, 256 and 512.
- `LINE_WIDTH`, 512, cache line width in bits; must be an integer multiple of `DATA_WIDTH`. BEATS = `LINE_WIDTH`/`DATA_WIDTH` (default 8).
- `clk` in 1: single clock; all logic is rising-edge.
- `arst` in 1: reset, asynchronous and active-high.
- `i_start_read` in 1: fetch request, sampled only in IDLE.
- `i_addr` in `ADDR_WIDTH`: miss address; the low log2(`LINE_WIDTH`/8) bits are ignored.
- `o_araddr` out `ADDR_WIDTH`: line-aligned burst address.
- `o_arlen` out 8: constant BEATS-1.
- `o_arsize` out 3: constant log2(`DATA_WIDTH`/8).
- `o_arburst` out 2: constant 2'b01 (INCR).
- `o_arvalid` out 1 / `i_arready` in 1: AR handshake.
- `i_rdata` in `DATA_WIDTH`, `i_rresp` in 2, `i_rlast` in 1, `i_rvalid` in 1 / `o_rready` out 1: R channel.
- `o_line` out `LINE_WIDTH`: assembled line.
- `o_read_last` out 1: one-cycle pulse meaning the line is complete and valid.
- `o_error` out 1: one-cycle pulse, coincident with `o_read_last`, when the burst was faulty.
- `o_busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE → ADDR on `i_start_read`=1. On that edge:
  - latch `i_addr` with the low offset bits zeroed into `o_araddr`;
  - clear the beat counter and the error flag.
- ADDR: `o_arvalid`=1. `o_araddr` is held stable until `i_arready`=1, then → DATA. `o_arvalid` is never withdrawn before the handshake.
- DATA: `o_rready`=1. On each `i_rvalid`&`o_rready`:
  - write beat k into `o_line[k*DATA_WIDTH +: DATA_WIDTH]` (beat 0 goes to the LSBs);
  - increment k;
  - set the error flag if `i_rresp[1]`=1 (SLVERR/DECERR), or if `i_rlast` ≠ (k==BEATS-1).
  - The accepted beat with k==BEATS-1 moves the FSM to DONE, regardless of `i_rlast`.
- DONE: `o_read_last`=1, and `o_error` = the error flag. Then → IDLE unconditionally.
- `i_start_read` in any state other than IDLE is ignored; it is not queued.
- `o_line` keeps its last contents until the first beat of the next burst. Its contents during DATA are partial and are not valid for the consumer.
- The block does not prevent a line from being written when `o_error`=1. The consumer must not write the cache when `o_error`=1.
- Reset mid-burst: the FSM returns to IDLE immediately and any outstanding AXI transaction is abandoned. Reset is system-wide, so the interconnect is reset with it.

## Timing
- Reset values:
  - FSM = IDLE;
  - `o_arvalid`, `o_rready`, `o_read_last`, `o_error`, `o_busy` = 0;
  - `o_araddr` and `o_line` = 0;
  - counter = 0.
- Constants `o_arlen`, `o_arsize`, `o_arburst` are driven continuously.
- Best case with `i_arready` and `i_rvalid` always high:
  - cycle 0: `i_start_read` sampled;
  - cycle 1: AR handshake;
  - cycles 2..BEATS+1: R beats;
  - cycle BEATS+2: `o_read_last` (cycle 10 for default parameters).
- Latency is BEATS+2 cycles plus every cycle of `i_arready`/`i_rvalid` stall.
- `o_rready` is asserted only in DATA. An `i_rvalid` arriving in ADDR is not accepted.
- `o_busy` goes high the cycle after `i_start_read` is sampled. It goes low the cycle after DONE, when a new request can be sampled.
- All outputs are registered. There is no combinational path from the R or AR inputs to any output.

## Test plan
- Basic fetch (default parameters):
  - stimulus: `i_addr`=0x1038; AXI slave always ready; beat k data = 0x1111_1111_1111_1111*k; `i_rlast` on beat 7;
  - required: `o_araddr`=0x1000, `o_arlen`=7, `o_arsize`=3, `o_arburst`=1; `o_read_last` at cycle 10; `o_line[63:0]`=0, `o_line[511:448]`=0x7777_7777_7777_7777; `o_error`=0.
- Backpressure:
  - stimulus: `i_arready` held low for 3 cycles; `i_rvalid` deasserted between every beat;
  - required: `o_araddr` stable while `o_arvalid`=1; line identical to the basic case; `o_read_last` exactly once.
- Error response:
  - stimulus: `i_rresp`=2'b10 on beat 3, case 1;
  - required: `o_error`=1 with `o_read_last`; all 8 beats still consumed.
- rlast mismatch:
  - stimulus: `i_rlast` on beat 5 (case 2), or never asserted (case 3);
  - required: in both cases `o_error`=1; DONE is reached after the 8th beat.
- Ignored request:
  - stimulus: `i_start_read` pulsed during DATA;
  - required: no second AR; `o_busy` low for exactly one cycle after `o_read_last`.
- Reset mid-burst:
  - stimulus: assert `arst` after beat 4, release it, then issue a new request;
  - required: all outputs 0 immediately; new fetch completes normally with the correct line.
